// File: rtl/uart_status_tx.sv
// ---------------------------------------------------------------------------
// uart_status_tx
//
// Serialises the game status bus into 4-byte UART packets for the host
// display. A packet goes out whenever the status word differs from the last
// one sent, or when the host logic pulses `enviar`.
//
// Packet layout (each byte LSB first, framed 8N1, or 8E1 when parity is on):
//   B0 = HEADER
//   B1 = {macro, micro}
//   B2 = {estado, resultado_macro, resultado_jogo}
//   B3 = B1 ^ B2
//
// Build option:
//   UART_STATUS_PARITY_EN  when defined, adds an even-parity bit after the
//                          data bits of every byte (8E1). The port list does
//                          not change.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (>= 2)
//   HEADER        first byte of every packet
//
// Ports:
//   clock            in  system clock, rising edge
//   reset            in  asynchronous, active-high reset
//   macro            in  [3:0] current macro board index
//   micro            in  [3:0] current micro cell index
//   estado           in  [3:0] control-unit state code
//   resultado_macro  in  [1:0] result of current macro board
//   resultado_jogo   in  [1:0] overall game result
//   enviar           in  single-cycle request to send even if unchanged
//   tx               out UART serial line, idle high
//   ocupado          out high while a packet is in flight
//   pacote_enviado   out one-cycle pulse after the last stop bit
// ---------------------------------------------------------------------------
module uart_status_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] macro,
  input  logic [3:0] micro,
  input  logic [3:0] estado,
  input  logic [1:0] resultado_macro,
  input  logic [1:0] resultado_jogo,
  input  logic       enviar,
  output logic       tx,
  output logic       ocupado,
  output logic       pacote_enviado
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

`ifdef UART_STATUS_PARITY_EN
  typedef enum logic [2:0] {
    OCIOSO, CARREGA, START, DADOS, PARIDADE, PARADA
  } fsm_t;
`else
  typedef enum logic [2:0] {
    OCIOSO, CARREGA, START, DADOS, PARADA
  } fsm_t;
`endif

  // Control state
  fsm_t              fsm_q;
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]        bit_q;
  logic [1:0]        byte_q;
  logic [15:0]       ultimo_q;
  logic              pendente_q;
  logic              tx_q;
  logic              ocupado_q;
  logic              enviado_q;

  // Frame data, captured once per packet
  logic [15:0]       snapshot_q;

  // Combinational helpers
  logic [15:0]       status_w;
  logic [BAUD_W-1:0] baud_d;
  logic              baud_fim;
  logic              dispara;
  logic [2:0]        bit_d;
  logic [7:0]        byte_atual;

  assign status_w = {macro, micro, estado, resultado_macro, resultado_jogo};

  // The baud counter runs in every bit-holding state and wraps on the last
  // cycle of a bit; that wrap is the only event that advances the FSM.
  assign baud_fim = (baud_q == BAUD_LAST);
  assign baud_d   = baud_fim ? '0 : baud_q + 1'b1;
  assign bit_d    = bit_q + 3'd1;

  // A pending request or a status change seen while busy both fold into the
  // same trigger, so any number of them during one packet yields one more.
  assign dispara = (status_w != ultimo_q) | enviar | pendente_q;

  // Byte currently on the wire, always derived from the snapshot so that
  // input activity mid-packet cannot tear the frame.
  always_comb begin
    byte_atual = HEADER;
    case (byte_q)
      2'd0:    byte_atual = HEADER;
      2'd1:    byte_atual = snapshot_q[15:8];
      2'd2:    byte_atual = snapshot_q[7:0];
      default: byte_atual = snapshot_q[15:8] ^ snapshot_q[7:0];
    endcase
  end

  // Snapshot register: loaded during CARREGA, holds for the whole packet.
  always_ff @(posedge clock) begin
    if (fsm_q == CARREGA) begin
      snapshot_q <= status_w;
    end
  end

  // Transmitter FSM with registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm_q      <= OCIOSO;
      baud_q     <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      ultimo_q   <= 16'hFFFF;
      pendente_q <= 1'b0;
      tx_q       <= 1'b1;
      ocupado_q  <= 1'b0;
      enviado_q  <= 1'b0;
    end else begin
      enviado_q <= 1'b0;

      // Requests arriving while busy are remembered; CARREGA below clears
      // them, since the snapshot taken there already satisfies them.
      if (enviar && ocupado_q) begin
        pendente_q <= 1'b1;
      end

      case (fsm_q)
        OCIOSO: begin
          if (dispara) begin
            fsm_q     <= CARREGA;
            ocupado_q <= 1'b1;
          end
        end

        CARREGA: begin
          ultimo_q   <= status_w;
          pendente_q <= 1'b0;
          byte_q     <= '0;
          bit_q      <= '0;
          baud_q     <= '0;
          tx_q       <= 1'b0;
          fsm_q      <= START;
        end

        START: begin
          baud_q <= baud_d;
          if (baud_fim) begin
            bit_q <= '0;
            tx_q  <= byte_atual[0];
            fsm_q <= DADOS;
          end
        end

        DADOS: begin
          baud_q <= baud_d;
          if (baud_fim) begin
            if (bit_q == 3'd7) begin
`ifdef UART_STATUS_PARITY_EN
              tx_q  <= ^byte_atual;
              fsm_q <= PARIDADE;
`else
              tx_q  <= 1'b1;
              fsm_q <= PARADA;
`endif
            end else begin
              bit_q <= bit_d;
              tx_q  <= byte_atual[bit_d];
            end
          end
        end

`ifdef UART_STATUS_PARITY_EN
        PARIDADE: begin
          baud_q <= baud_d;
          if (baud_fim) begin
            tx_q  <= 1'b1;
            fsm_q <= PARADA;
          end
        end
`endif

        PARADA: begin
          baud_q <= baud_d;
          if (baud_fim) begin
            if (byte_q == 2'd3) begin
              fsm_q     <= OCIOSO;
              ocupado_q <= 1'b0;
              enviado_q <= 1'b1;
            end else begin
              byte_q <= byte_q + 2'd1;
              tx_q   <= 1'b0;
              fsm_q  <= START;
            end
          end
        end

        default: begin
          fsm_q     <= OCIOSO;
          ocupado_q <= 1'b0;
          tx_q      <= 1'b1;
        end
      endcase
    end
  end

  assign tx             = tx_q;
  assign ocupado        = ocupado_q;
  assign pacote_enviado = enviado_q;

endmodule
